pps_gate_counter: RTL and testbench
===================================

# pps_gate_counter

Parametrised GPS-disciplined gated frequency counter. It counts system-clock cycles across a runtime-selectable number of GPS PPS intervals, with back-to-back gates and no dead time. It presents each result through a valid/ack handshake with saturation and overrun flags, and detects a missing PPS by timeout. It sits between the GPS pulse pin and the SPI register map, replacing the hand-coded counter logic in the FPGA top level.

## Interface

Parameters:

- WIDTH, 35, result/counter width in bits
- GATE_BITS, 4, width of gate_len
- SYNC_STAGES, 2, synchroniser flops on pps_in (>=2)
- TIMEOUT_CYCLES, 30000000, clk cycles without a PPS edge before pps_missing asserts

Ports:

- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- pps_in  in  1  raw GPS pulse, asynchronous to clk
- enable  in  1  measurement enable
- gate_len  in  GATE_BITS  gate length is gate_len+1 PPS intervals; sampled at gate open
- result  out  WIDTH  last completed measurement in clk cycles
- result_valid  out  1  result unread
- result_saturated  out  1  counter hit all-ones during the gate of the current result
- result_overrun  out  1  unread result was overwritten; sticky
- result_ack  in  1  consumer has read result
- pps_missing  out  1  timeout elapsed without an edge
- state  out  2  0 = IDLE, 1 = ARM, 2 = COUNT

## Operation

- **Synchroniser:** pps_in passes through SYNC_STAGES flops. A registered rising-edge detect gives a 1-cycle `edge`.
- **Reset:** all outputs and internal registers are 0, state IDLE.
- **IDLE:**
  - enable=1 -> ARM on the next cycle.
  - In any state, enable=0 -> IDLE next cycle. This clears count, interval count and timeout counter.
  - result, flags and pps_missing are retained.
- **ARM:** on `edge`, this is the gate open:
  - count<=1, intervals<=0, gate_reg<=gate_len.
  - Clear pps_missing, go to COUNT.
- **COUNT:**
  - On a cycle without `edge`: count<=count+1. If count is all-ones it holds and sat<=1.
  - On `edge` with intervals!=gate_reg: intervals+1, and count keeps incrementing as above.
  - On `edge` with intervals==gate_reg (close):
    - result<=count, result_saturated<=sat, result_valid<=1.
    - The same edge reopens the next gate: count<=1, intervals<=0, sat<=0, gate_reg<=gate_len.
  - Result value is the difference in clk-cycle index between the opening and closing `edge`.
- **Timeout:**
  - The timeout counter resets on every `edge` and on entry to ARM from IDLE.
  - In ARM or COUNT, reaching TIMEOUT_CYCLES -> pps_missing<=1 and state<=ARM. The partial gate is discarded and result is untouched.
- **Handshake:**
  - result_ack with result_valid=1 clears result_valid and result_overrun. result_ack with result_valid=0 is ignored.
  - Close while valid=1 and no ack: result overwritten, valid stays 1, result_overrun<=1.
  - Close and ack in the same cycle: new result written, valid stays 1, overrun<=0.
- **Width rules:**
  - count/result are WIDTH bits, unsigned, saturating, never wrapping.
  - The interval counter is GATE_BITS wide.
  - The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

## Timing

- A pps_in rise meeting setup produces `edge` SYNC_STAGES+1 cycles later. Pulses shorter than one clk may be missed.
- result, result_valid and result_saturated update in the cycle after the closing `edge`. state changes in the cycle after its cause.
- result_valid clears the cycle after the ack.
- pps_missing asserts exactly TIMEOUT_CYCLES cycles after the last `edge`, and clears the cycle after the next `edge`.
- rst asserted mid-operation zeroes every output immediately, regardless of clk. Release is synchronous to clk. The first `edge` after release needs a fresh ARM.
- gate_len changes mid-gate do not affect the gate in progress.

## Test plan

Bench parameters: WIDTH=16, SYNC_STAGES=2, TIMEOUT_CYCLES=1000.

1. gate_len=0, enable=1, pps every 100 clk -> first result=100, valid 1 cycle after the 2nd edge; thereafter 100 every 100 cycles, no dead time; saturated=0.
2. gate_len=3, pps every 50 clk; gate_len changed to 0 mid-gate -> result=200; the following gate uses 1 interval -> 50.
3. WIDTH=8 build, pps every 300 clk -> result=255, result_saturated=1; next gate at 200 clk -> 200, saturated=0.
4. Overrun/handshake: no ack across two closes -> result=latest, overrun=1, valid=1; ack -> valid=0, overrun=0; ack in the same cycle as a close -> valid stays 1, overrun=0; ack with valid=0 -> no change.
5. PPS stops mid-gate -> pps_missing=1 exactly 1000 cycles after the last edge, state=ARM, result unchanged; PPS resumes at 100 -> missing clears after the 1st edge, next result=100 after the 2nd edge.
6. rst pulse mid-COUNT -> all outputs 0 asynchronously; enable=0 mid-gate -> IDLE, prior result/valid retained, no new result until re-armed and two edges seen.

Source files
------------

// File: rtl/pps_gate_counter.sv
// GPS-disciplined gated frequency counter: counts clk cycles across
// gate_len+1 PPS intervals with back-to-back gates, a valid/ack result
// handshake, saturation/overrun flags and a missing-PPS timeout.
module pps_gate_counter #(
  parameter int unsigned WIDTH          = 35,
  parameter int unsigned GATE_BITS      = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 30000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pps_in,
  input  logic                 enable,
  input  logic [GATE_BITS-1:0] gate_len,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid,
  output logic                 result_saturated,
  output logic                 result_overrun,
  input  logic                 result_ack,
  output logic                 pps_missing,
  output logic [1:0]           state
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 pps_prev_q;
  logic                 pps_edge_q;

  logic [WIDTH-1:0]     count_q, count_d;
  logic                 sat_q, sat_d;
  logic [GATE_BITS-1:0] intervals_q, intervals_d;
  logic [GATE_BITS-1:0] gate_q, gate_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 valid_q, valid_d;
  logic                 res_sat_q, res_sat_d;
  logic                 overrun_q, overrun_d;
  logic                 missing_q, missing_d;

  logic [WIDTH-1:0]     count_step;
  logic                 sat_step;
  logic [TW-1:0]        tcnt_step;
  logic                 timeout_hit;
  logic                 close;

  // Synchronise pps_in and produce a registered one-cycle rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      pps_prev_q <= 1'b0;
      pps_edge_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pps_in};
      pps_prev_q <= sync_q[SYNC_STAGES-1];
      pps_edge_q <= sync_q[SYNC_STAGES-1] & ~pps_prev_q;
    end
  end

  // Saturating increments shared by the count and timeout paths.
  always_comb begin
    count_step  = (count_q == '1) ? count_q : count_q + 1'b1;
    sat_step    = sat_q | (count_q == '1);
    tcnt_step   = (tcnt_q == TIMEOUT_VAL) ? tcnt_q : tcnt_q + 1'b1;
    timeout_hit = (tcnt_step == TIMEOUT_VAL);
  end

  // Next-state, gate bookkeeping and result handshake.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sat_d       = sat_q;
    intervals_d = intervals_q;
    gate_d      = gate_q;
    tcnt_d      = tcnt_q;
    result_d    = result_q;
    valid_d     = valid_q;
    res_sat_d   = res_sat_q;
    overrun_d   = overrun_q;
    missing_d   = missing_q;
    close       = 1'b0;

    // tcnt holds the number of cycles since the last edge, so the cycle
    // after an edge already reads 1; timeout then lands exactly
    // TIMEOUT_CYCLES cycles after the edge.
    if (!enable) begin
      state_d     = IDLE;
      count_d     = '0;
      sat_d       = 1'b0;
      intervals_d = '0;
      tcnt_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          tcnt_d  = '0;
        end
        ARM: begin
          if (pps_edge_q) begin
            state_d     = COUNT;
            count_d     = WIDTH'(1);
            sat_d       = 1'b0;
            intervals_d = '0;
            gate_d      = gate_len;
            missing_d   = 1'b0;
            tcnt_d      = TW'(1);
          end else begin
            tcnt_d = tcnt_step;
            if (timeout_hit) missing_d = 1'b1;
          end
        end
        COUNT: begin
          if (pps_edge_q) begin
            tcnt_d = TW'(1);
            if (intervals_q == gate_q) begin
              close       = 1'b1;
              count_d     = WIDTH'(1);
              sat_d       = 1'b0;
              intervals_d = '0;
              gate_d      = gate_len;
            end else begin
              intervals_d = intervals_q + 1'b1;
              count_d     = count_step;
              sat_d       = sat_step;
            end
          end else begin
            tcnt_d  = tcnt_step;
            count_d = count_step;
            sat_d   = sat_step;
            if (timeout_hit) begin
              missing_d = 1'b1;
              state_d   = ARM;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (close) begin
      result_d  = count_q;
      res_sat_d = sat_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~result_ack;
    end else if (result_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      sat_q       <= 1'b0;
      intervals_q <= '0;
      gate_q      <= '0;
      tcnt_q      <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      res_sat_q   <= 1'b0;
      overrun_q   <= 1'b0;
      missing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      intervals_q <= intervals_d;
      gate_q      <= gate_d;
      tcnt_q      <= tcnt_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      res_sat_q   <= res_sat_d;
      overrun_q   <= overrun_d;
      missing_q   <= missing_d;
    end
  end

  assign result           = result_q;
  assign result_valid     = valid_q;
  assign result_saturated = res_sat_q;
  assign result_overrun   = overrun_q;
  assign pps_missing      = missing_q;
  assign state            = state_q;

endmodule

// File: tb/tb_pps_gate_counter.sv
// Self-checking bench for pps_gate_counter: a 16-bit and an 8-bit build share
// one stimulus stream and are compared every cycle against a gate-level model
// that works in terms of edge cycle indices and gate lengths.
module tb_pps_gate_counter;

  localparam int S  = 2;
  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps_in = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  gate_len = '0;
  logic        result_ack = 1'b0;

  logic [15:0] r16;
  logic        v16, s16, o16, m16;
  logic [1:0]  st16;
  logic [7:0]  r8;
  logic        v8, s8, o8, m8;
  logic [1:0]  st8;

  int checks = 0;
  int errors = 0;
  bit ack_rand = 0;

  pps_gate_counter #(.WIDTH(16), .GATE_BITS(4), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) u16 (
    .clk(clk), .rst(rst), .pps_in(pps_in), .enable(enable), .gate_len(gate_len),
    .result(r16), .result_valid(v16), .result_saturated(s16), .result_overrun(o16),
    .result_ack(result_ack), .pps_missing(m16), .state(st16));

  pps_gate_counter #(.WIDTH(8), .GATE_BITS(4), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) u8 (
    .clk(clk), .rst(rst), .pps_in(pps_in), .enable(enable), .gate_len(gate_len),
    .result(r8), .result_valid(v8), .result_saturated(s8), .result_overrun(o8),
    .result_ack(result_ack), .pps_missing(m8), .state(st8));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 arm, 2 count. Times are posedge indices; an edge seen in
  // cycle c is acted on at posedge c+1.
  int   kc = 0;
  int   mode = 0;
  int   open_c = 0, last_ev = 0, edges = 0, target = 0;
  int   m_len = 0;
  bit   m_valid = 0, m_ovr = 0, m_miss = 0;
  logic [7:0] ph = '0;

  function automatic longint cap(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    bit ev, close;
    int len;
    forever begin
      @(posedge clk);
      kc++;
      if (rst) begin
        ph = '0; mode = 0; m_len = 0; m_valid = 0; m_ovr = 0; m_miss = 0;
        edges = 0; target = 0;
      end else begin
        // edge visible in the previous cycle: pps rose S+1 cycles before it
        ev = ph[S] & ~ph[S+1];
        ph = {ph[6:0], pps_in};
        close = 0;
        len = 0;
        if (!enable) mode = 0;
        else if (mode == 0) begin
          mode = 1; last_ev = kc;
        end else if (ev) begin
          last_ev = kc - 1;
          if (mode == 1) begin
            mode = 2; m_miss = 0; open_c = kc - 1; edges = 0; target = int'(gate_len);
          end else if (edges == target) begin
            close = 1; len = kc - 1 - open_c;
            open_c = kc - 1; edges = 0; target = int'(gate_len);
          end else edges++;
        end else if (kc - last_ev == TO) begin
          m_miss = 1; mode = 1;
        end
        if (close) begin
          m_len = len; m_ovr = m_valid && !result_ack; m_valid = 1;
        end else if (result_ack && m_valid) begin
          m_valid = 0; m_ovr = 0;
        end
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("state16", st16, mode);
      chk("state8", st8, mode);
      chk("result16", r16, cap(m_len, 65535));
      chk("sat16", s16, m_len > 65535);
      chk("result8", r8, cap(m_len, 255));
      chk("sat8", s8, m_len > 255);
      chk("valid16", v16, m_valid);
      chk("valid8", v8, m_valid);
      chk("overrun16", o16, m_ovr);
      chk("overrun8", o8, m_ovr);
      chk("missing16", m16, m_miss);
      chk("missing8", m8, m_miss);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input int period, input int ack_at);
    int w;
    w = $urandom_range(1, (period - 1 < 8) ? period - 1 : 8);
    for (int i = 0; i < period; i++) begin
      pps_in = (i < w);
      if (ack_rand) result_ack = ($urandom_range(0, 7) == 0);
      else result_ack = (i == ack_at);
      @(negedge clk);
    end
    result_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pps_in = 1'b0;
      result_ack = ack_rand ? ($urandom_range(0, 7) == 0) : 1'b0;
      @(negedge clk);
    end
    result_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    repeat (3) @(negedge clk);
    chk("rst_result", r16, 0); chk("rst_valid", v16, 0); chk("rst_state", st16, 0);
    chk("rst_missing", m16, 0); chk("rst_overrun", o16, 0); chk("rst_sat", s16, 0);
    rst = 1'b0;

    // gate_len=0, PPS every 100
    enable = 1'b1; gate_len = 4'd0;
    idle(3);
    chk("t1_arm", st16, 1);
    repeat (4) pulse(100, -1);
    chk("t1_result", r16, 100); chk("t1_valid", v16, 1); chk("t1_sat", s16, 0);
    chk("t1_overrun", o16, 1); chk("t1_state", st16, 2);
    pulse(100, 3);
    chk("t4_close_ack_valid", v16, 1); chk("t4_close_ack_ovr", o16, 0);

    // gate_len=3 then changed mid-gate
    gate_len = 4'd3;
    pulse(50, -1); pulse(50, -1); pulse(50, -1);
    gate_len = 4'd0;
    pulse(50, -1); pulse(50, -1);
    chk("t2_result200", r16, 200);
    pulse(50, -1);
    chk("t2_result50", r16, 50);

    // handshake
    ack_pulse();
    chk("t4_ack_valid", v16, 0); chk("t4_ack_ovr", o16, 0);
    ack_pulse();
    chk("t4_noop_valid", v16, 0); chk("t4_noop_result", r16, 50);

    // saturation in the 8-bit build
    pulse(300, -1); pulse(256, -1);
    chk("t3_r8_300", r8, 255); chk("t3_s8_300", s8, 1);
    chk("t3_r16_300", r16, 300); chk("t3_s16_300", s16, 0); chk("t3_ovr", o16, 1);
    pulse(255, -1);
    chk("t3_r8_256", r8, 255); chk("t3_s8_256", s8, 1);
    pulse(200, -1);
    chk("t3_r8_255", r8, 255); chk("t3_s8_255", s8, 0);
    pulse(100, -1);
    chk("t3_r8_200", r8, 200); chk("t3_s8_200", s8, 0);

    // PPS stops mid-gate
    gate_len = 4'd3;
    pulse(100, -1); pulse(100, -1);
    idle(902);
    chk("t5_missing_early", m16, 0);
    idle(1);
    chk("t5_missing", m16, 1); chk("t5_state", st16, 1); chk("t5_result", r16, 100);
    ack_pulse();
    idle(50);
    gate_len = 4'd0;
    pulse(100, -1);
    chk("t5_missing_clr", m16, 0); chk("t5_count", st16, 2); chk("t5_no_result", v16, 0);
    pulse(100, -1);
    chk("t5_result_after", r16, 100); chk("t5_valid_after", v16, 1);

    // async reset mid-gate, then enable drop mid-gate
    pulse(100, -1);
    idle(20);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_result", r16, 0); chk("t6_rst_valid", v16, 0); chk("t6_rst_state", st16, 0);
    chk("t6_rst_missing", m16, 0); chk("t6_rst_ovr", o16, 0); chk("t6_rst_sat", s16, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("t6_rearm", st16, 1);
    pulse(80, -1); pulse(80, -1);
    chk("t6_result80", r16, 80); chk("t6_valid80", v16, 1);
    pulse(80, -1);
    enable = 1'b0;
    idle(10);
    chk("t6_idle", st16, 0); chk("t6_kept_result", r16, 80); chk("t6_kept_valid", v16, 1);
    enable = 1'b1;
    idle(3);
    pulse(60, -1);
    chk("t6_one_edge", r16, 80);
    pulse(60, -1);
    chk("t6_result60", r16, 60);

    // randomized traffic
    ack_rand = 1;
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 5) == 0) gate_len = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 11) == 0) begin
        enable = 1'b0;
        idle($urandom_range(1, 20));
        enable = 1'b1;
      end
      p = ($urandom_range(0, 9) == 0) ? $urandom_range(995, 1005) : $urandom_range(5, 300);
      pulse(p, -1);
    end
    ack_rand = 0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
